// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_multicycle_control_if : control <-> datapath signal bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface mips_multicycle_control_if #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic               trap;
  logic [CNT_W-1:0]   retired;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, trap, retired, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, trap, retired, state_o
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_multicycle_control : Moore control FSM for a multicycle MIPS datapath
// Revision 1.0
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_isStore;
  logic             r_trap;
  logic [CNT_W-1:0] r_retired;

  logic       r_pcWrite;
  logic       r_pcWriteCond;
  logic [1:0] r_pcSource;
  logic       r_iOrD;
  logic       r_memRead;
  logic       r_memWrite;
  logic       r_regWrite;
  logic       r_regDst;
  logic       r_memToReg;
  logic       r_aluSrcA;
  logic [1:0] r_aluSrcB;
  logic [1:0] r_aluOp;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:  if (bus.mem_ready) w_nextState = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_nextState = EXEC;
          OP_LW, OP_SW: w_nextState = MEMADR;
          OP_BEQ:       w_nextState = BRANCH;
          OP_J:         w_nextState = JUMP;
          OP_ADDI:      w_nextState = ADDIEX;
          default:      w_nextState = TRAP;
        endcase
      end
      MEMADR: w_nextState = r_isStore ? MEMWR : MEMRD;
      MEMRD:  if (bus.mem_ready) w_nextState = MEMWB;
      MEMWR:  if (bus.mem_ready) w_nextState = FETCH;
      EXEC:   w_nextState = ALUWB;
      ADDIEX: w_nextState = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: w_nextState = FETCH;
      TRAP:   w_nextState = TRAP;
      default: w_nextState = FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_isStore     <= 1'b0;
      r_trap        <= 1'b0;
      r_retired     <= '0;
      r_pcWrite     <= 1'b0;
      r_pcWriteCond <= 1'b0;
      r_pcSource    <= 2'd0;
      r_iOrD        <= 1'b0;
      r_memRead     <= 1'b1;
      r_memWrite    <= 1'b0;
      r_regWrite    <= 1'b0;
      r_regDst      <= 1'b0;
      r_memToReg    <= 1'b0;
      r_aluSrcA     <= 1'b0;
      r_aluSrcB     <= 2'd1;
      r_aluOp       <= 2'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == DECODE) r_isStore <= (bus.opcode == OP_SW);
      if (w_nextState == TRAP) r_trap <= 1'b1;
      if (w_nextState == FETCH && r_state != FETCH) r_retired <= r_retired + 1'b1;

      r_pcWrite     <= 1'b0;
      r_pcWriteCond <= 1'b0;
      r_pcSource    <= 2'd0;
      r_iOrD        <= 1'b0;
      r_memRead     <= 1'b0;
      r_memWrite    <= 1'b0;
      r_regWrite    <= 1'b0;
      r_regDst      <= 1'b0;
      r_memToReg    <= 1'b0;
      r_aluSrcA     <= 1'b0;
      r_aluSrcB     <= 2'd0;
      r_aluOp       <= 2'd0;
      case (w_nextState)
        FETCH:  begin r_memRead <= 1'b1; r_aluSrcB <= 2'd1; end
        DECODE: r_aluSrcB <= 2'd3;
        MEMADR: begin r_aluSrcA <= 1'b1; r_aluSrcB <= 2'd2; end
        MEMRD:  begin r_memRead <= 1'b1; r_iOrD <= 1'b1; end
        MEMWB:  begin r_regWrite <= 1'b1; r_memToReg <= 1'b1; end
        MEMWR:  begin r_memWrite <= 1'b1; r_iOrD <= 1'b1; end
        EXEC:   begin r_aluSrcA <= 1'b1; r_aluOp <= 2'd2; end
        ALUWB:  begin r_regWrite <= 1'b1; r_regDst <= 1'b1; end
        BRANCH: begin
          r_aluSrcA     <= 1'b1;
          r_aluOp       <= 2'd1;
          r_pcWriteCond <= 1'b1;
          r_pcSource    <= 2'd1;
        end
        JUMP:   begin r_pcWrite <= 1'b1; r_pcSource <= 2'd2; end
        ADDIEX: begin r_aluSrcA <= 1'b1; r_aluSrcB <= 2'd2; end
        ADDIWB: r_regWrite <= 1'b1;
        default: ;
      endcase
    end
  end

  logic w_fetchDone;
  assign w_fetchDone = (r_state == FETCH) && bus.mem_ready;

  // Gating with rst_n drops every strobe the instant reset asserts.
  assign bus.pc_write      = rst_n & (r_pcWrite | w_fetchDone);
  assign bus.ir_write      = rst_n & w_fetchDone;
  assign bus.pc_write_cond = rst_n & r_pcWriteCond;
  assign bus.pc_source     = rst_n ? r_pcSource : 2'd0;
  assign bus.i_or_d        = rst_n & r_iOrD;
  assign bus.mem_read      = rst_n & r_memRead;
  assign bus.mem_write     = rst_n & r_memWrite;
  assign bus.reg_write     = rst_n & r_regWrite;
  assign bus.reg_dst       = rst_n & r_regDst;
  assign bus.mem_to_reg    = rst_n & r_memToReg;
  assign bus.alu_src_a     = rst_n & r_aluSrcA;
  assign bus.alu_src_b     = rst_n ? r_aluSrcB : 2'd0;
  assign bus.alu_op        = rst_n ? r_aluOp : 2'd0;
  assign bus.trap          = r_trap;
  assign bus.retired       = r_retired;
  assign bus.state_o       = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_multicycle_control : directed self-checking bench for the control FSM
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   mwCount;
  logic expTrap;

  mips_multicycle_control_if #(.CNT_W(32), .STATE_W(4)) bus ();

  mips_multicycle_control #(.CNT_W(32), .STATE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // {pw, pwc, ps[1:0], iod, mr, mw, irw, rw, rd, m2r, asa, asb[1:0], aop[1:0], trap}
  function automatic logic [16:0] ctrlNow();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.trap};
  endfunction

  function automatic logic [16:0] expCtrl(input int st, input logic rdy, input logic tr);
    logic pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa;
    logic [1:0] ps, asb, aop;
    {pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa} = '0;
    ps = 2'd0; asb = 2'd0; aop = 2'd0;
    case (st)
      0:  begin mr = 1'b1; asb = 2'd1; pw = rdy; irw = rdy; end
      1:  asb = 2'd3;
      2:  begin asa = 1'b1; asb = 2'd2; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'd2; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'd1; pwc = 1'b1; ps = 2'd1; end
      9:  begin pw = 1'b1; ps = 2'd2; end
      10: begin asa = 1'b1; asb = 2'd2; end
      11: rw = 1'b1;
      default: ;
    endcase
    return {pw, pwc, ps, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, tr};
  endfunction

  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic cyc(input int expState, input string tag);
    #1;
    checkVal({tag, "_state"}, 32'(bus.state_o), 32'(expState));
    checkVal({tag, "_ctrl"}, 32'(ctrlNow()), 32'(expCtrl(expState, bus.mem_ready, expTrap)));
    if (bus.mem_write) mwCount++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    expTrap = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_state", 32'(bus.state_o), 32'd0);
    checkVal("rst_ctrl", 32'(ctrlNow()), 32'd0);
    checkVal("rst_retired", bus.retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; mwCount = 0; expTrap = 1'b0;
    rst_n = 1'b0;
    bus.opcode = 6'b000000; bus.zero = 1'b0; bus.mem_ready = 1'b1;

    // R-type
    doReset();
    bus.opcode = 6'b000000; bus.mem_ready = 1'b1;
    cyc(0, "r0"); cyc(1, "r1"); cyc(6, "r6"); cyc(7, "r7"); cyc(0, "r0b");
    checkVal("r_retired", bus.retired, 32'd1);

    // lw with two stall cycles
    doReset();
    bus.opcode = 6'b100011;
    cyc(0, "lw0"); cyc(1, "lw1"); cyc(2, "lw2");
    bus.mem_ready = 1'b0;
    cyc(3, "lw3a"); cyc(3, "lw3b");
    bus.mem_ready = 1'b1;
    cyc(3, "lw3c"); cyc(4, "lw4"); cyc(0, "lw0b");
    checkVal("lw_retired", bus.retired, 32'd1);

    // beq taken then not taken
    doReset();
    bus.opcode = 6'b000100; bus.zero = 1'b1;
    cyc(0, "bq0"); cyc(1, "bq1"); cyc(8, "bq8");
    bus.zero = 1'b0;
    cyc(0, "bn0"); cyc(1, "bn1"); cyc(8, "bn8"); cyc(0, "bn0b");
    checkVal("beq_retired", bus.retired, 32'd2);

    // illegal opcode
    doReset();
    bus.opcode = 6'b111111;
    cyc(0, "tp0"); cyc(1, "tp1");
    expTrap = 1'b1;
    for (int i = 0; i < 20; i++) cyc(12, "tp12");
    checkVal("trap_retired", bus.retired, 32'd0);
    doReset();
    checkVal("trap_cleared", 32'(bus.trap), 32'd0);
    cyc(0, "tpr0");

    // reset in the middle of a stalled sw
    doReset();
    bus.opcode = 6'b101011;
    cyc(0, "sr0"); cyc(1, "sr1"); cyc(2, "sr2");
    bus.mem_ready = 1'b0;
    cyc(5, "sr5a");
    #1;
    checkVal("sr_mw_before", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("sr_mw_async", 32'(bus.mem_write), 32'd0);
    checkVal("sr_state_async", 32'(bus.state_o), 32'd0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    rst_n = 1'b1;
    cyc(0, "sr0b");
    checkVal("sr_retired", bus.retired, 32'd0);

    // j, addi, sw back to back: 3 + 4 + 4 cycles
    doReset();
    mwCount = 0;
    bus.opcode = 6'b000010;
    cyc(0, "j0"); cyc(1, "j1"); cyc(9, "j9");
    bus.opcode = 6'b001000;
    cyc(0, "a0"); cyc(1, "a1"); cyc(10, "a10"); cyc(11, "a11");
    bus.opcode = 6'b101011;
    cyc(0, "s0"); cyc(1, "s1"); cyc(2, "s2"); cyc(5, "s5");
    #1;
    checkVal("seq_state", 32'(bus.state_o), 32'd0);
    checkVal("seq_retired", bus.retired, 32'd3);
    checkVal("seq_mw_cycles", 32'(mwCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style control FSM that sequences the shared MIPS datapath in multicycle form: PC, single unified memory port, register file, ALU, sign-extend/shift.
- Each instruction takes FETCH, DECODE, then opcode-specific EX/MEM/WB states.
- Drives every datapath select and write strobe.
- Stretches memory states on a ready handshake, counts retired instructions, and traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- STATE_W, 4, width of state_o debug output.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset
- opcode  input  6  IR[31:26] from instruction register
- zero  input  1  ALU zero flag (BEQ)
- mem_ready  input  1  memory completes current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if zero=1
- pc_source  output  2  0=ALU out, 1=ALUOut reg (branch target), 2=jump target
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  load instruction register
- reg_write  output  1  register file write enable
- reg_dst  output  1  write reg select: 0=rt, 1=rd
- mem_to_reg  output  1  write data select: 0=ALUOut, 1=MDR
- alu_src_a  output  1  0=PC, 1=A reg
- alu_src_b  output  2  0=B reg, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- trap  output  1  illegal opcode seen; sticky
- retired  output  CNT_W  count of completed instructions
- state_o  output  STATE_W  current state encoding (debug)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst). rst low → state=FETCH, retired=0, trap=0, all strobes/selects forced 0 regardless of state. First cycle after rst rises: FETCH outputs active.
- State encoding (state_o): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- Default for every output not listed in a state: 0.
- FETCH: mem_read=1, alu_src_b=1, alu_op=00. If mem_ready: ir_write=1, pc_write=1, pc_source=0 → DECODE. Else hold, with ir_write/pc_write=0.
- DECODE: alu_src_b=3, alu_op=00 (branch target precompute). Next state by opcode:
  - 000000 → EXEC
  - 100011/101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other → TRAP
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=00 → MEMRD if lw, MEMWR if sw.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then → FETCH. mem_write stays high for the whole stall.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=10 → ALUWB.
- ALUWB: reg_write=1, reg_dst=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_write_cond=1, pc_source=1 → FETCH.
- JUMP: pc_write=1, pc_source=2 → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=00 → ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0 → FETCH.
- TRAP: all strobes 0, trap=1. Stays until rst. trap is a register, set on the DECODE→TRAP transition.
- retired increments by 1 on every transition into FETCH from a non-FETCH state, and wraps modulo 2^CNT_W.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Reset mid-instruction: all strobes drop asynchronously; no partial write may complete after the rst falling edge.
- opcode and zero are sampled only in DECODE and BRANCH respectively.

Test Plan:
- rst low 3 cycles, then release, mem_ready=1, opcode=000000 → state_o sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired=1.
- lw (100011), mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; mem_read and i_or_d high throughout state 3; retired=1.
- beq with zero=1, then beq with zero=0 → pc_write_cond=1 and pc_source=1 in state 8 both times; 3 cycles each; retired=2.
- opcode=111111 in DECODE → state 12, trap=1, all strobes 0 for 20 cycles; retired unchanged; rst pulse → trap=0, state 0.
- Assert rst low mid-MEMWR while mem_ready=0 → mem_write falls in the same cycle (async); after release, state 0 and retired=0.
- Sequence of j, addi, sw with mem_ready=1 → total 11 cycles; retired=3; mem_write high for exactly 1 cycle.
